// File: rtl/gpr_multiport_pkg.sv
// Shared definitions for the multiport register file: controller states and
// default geometry.
package gpr_multiport_pkg;

  localparam int GPR_DATA_W = 32;
  localparam int GPR_ADDR_W = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } gpr_state_e;

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register pending-write bits. A set beats a same-cycle clear, and a flush
// beats everything.
module gpr_scoreboard
  import gpr_multiport_pkg::*;
#(
  parameter int ADDR_W = GPR_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   set,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   clear0,
  input  logic [ADDR_W-1:0]      clear0_addr,
  input  logic                   clear1,
  input  logic [ADDR_W-1:0]      clear1_addr,
  output logic [(2**ADDR_W)-1:0] pend
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] one_s;
  logic [DEPTH-1:0] set_mask_s;
  logic [DEPTH-1:0] clr_mask_s;
  logic [DEPTH-1:0] pend_nxt_s;
  logic [DEPTH-1:0] pend_r;

  assign one_s = {{(DEPTH-1){1'b0}}, 1'b1};

  // Next pending vector: clears are applied first so that a set always wins.
  always_comb begin
    set_mask_s = set ? (one_s << set_addr) : {DEPTH{1'b0}};
    clr_mask_s = (clear0 ? (one_s << clear0_addr) : {DEPTH{1'b0}})
               | (clear1 ? (one_s << clear1_addr) : {DEPTH{1'b0}});
    pend_nxt_s = flush ? {DEPTH{1'b0}} : ((pend_r & ~clr_mask_s) | set_mask_s);
  end

  // Pending bits register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= {DEPTH{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  assign pend = pend_r;

endmodule

// File: rtl/gpr_multiport.sv
// General-purpose register file: NUM_RD combinational read ports with
// write-first bypass, two write ports (port 1 wins), sequential array clear.
module gpr_multiport
  import gpr_multiport_pkg::*;
#(
  parameter int DATA_W  = GPR_DATA_W,
  parameter int ADDR_W  = GPR_ADDR_W,
  parameter int NUM_RD  = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     clr_req,
  output logic                     ready,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [(2**ADDR_W)-1:0]   pend
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  gpr_state_e        state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              ready_s, we0_ok_s, we1_ok_s, sb_ok_s;

  function automatic logic is_r0(input logic [ADDR_W-1:0] a);
    return (ZERO_R0 != 0) && (a == {ADDR_W{1'b0}});
  endfunction

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    if (!ready_s || is_r0(a)) begin
      v = {DATA_W{1'b0}};
    end else if (we1 && (a == waddr1)) begin
      v = wdata1;
    end else if (we0 && (a == waddr0)) begin
      v = wdata0;
    end else begin
      v = mem_r[a];
    end
    return v;
  endfunction

  assign ready_s  = (state_r == ST_IDLE);
  assign ready    = ready_s;
  assign we0_ok_s = we0 && ready_s && !is_r0(waddr0);
  assign we1_ok_s = we1 && ready_s && !is_r0(waddr1);
  assign sb_ok_s  = sb_set && ready_s && !is_r0(sb_addr);

  // Controller state and clear-address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_CLEAR;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Leave CLEAR on the same edge that zeroes the last address; the wide
  // counter lets the increment reach DEPTH without wrapping to zero.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    cnt_inc_s   = cnt_r + CNT_W'(1);
    case (state_r)
      ST_CLEAR: begin
        if (clr_req) begin
          cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_inc_s == CNT_W'(DEPTH)) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_CLEAR;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Storage array; port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!ready_s) begin
      mem_r[cnt_r[ADDR_W-1:0]] <= {DATA_W{1'b0}};
    end else begin
      if (we0_ok_s) mem_r[waddr0] <= wdata0;
      if (we1_ok_s) mem_r[waddr1] <= wdata1;
    end
  end

  // Zero-latency read ports.
  always_comb begin
    rdata = {(NUM_RD*DATA_W){1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      rdata[k*DATA_W +: DATA_W] = read_port(raddr[k*ADDR_W +: ADDR_W]);
    end
  end

  gpr_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (clr_req && ready_s),
    .set         (sb_ok_s),
    .set_addr    (sb_addr),
    .clear0      (we0_ok_s),
    .clear0_addr (waddr0),
    .clear1      (we1_ok_s),
    .clear1_addr (waddr1),
    .pend        (pend)
  );

endmodule

// File: doc/gpr_multiport.md
GPR_MULTIPORT -- requirements
Module: gpr_multiport

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register address width; DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have parameter NUM_RD, default 2, number of read ports.
REQ-004 The block SHALL have parameter ZERO_R0, default 1, meaning register 0 is hardwired to zero when 1.
REQ-005 The block SHALL have the following ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- RADDR  in  NUM_RD*ADDR_W  read addresses; port k occupies slice k.
- RDATA  out  NUM_RD*DATA_W  read data; port k occupies slice k.
- WE0, WADDR0, WDATA0  in  1/ADDR_W/DATA_W  write port 0.
- WE1, WADDR1, WDATA1  in  1/ADDR_W/DATA_W  write port 1, which has priority over port 0.
- CLR_REQ  in  1  pulse that requests a full array clear.
- READY  out  1  array is valid and accepting writes.
- SB_SET, SB_ADDR  in  1/ADDR_W  marks a register as having a write pending.
- PEND  out  DEPTH  per-register pending-write bits.

Function
REQ-006 Reads SHALL be combinational, with zero latency.
REQ-007 Write-first bypass: when a read address equals an enabled write address in the same cycle, RDATA SHALL return that write data; if both write ports match, WDATA1 SHALL be returned.
REQ-008 Writes SHALL commit on the rising CLK edge when READY=1.
REQ-009 When WE0 and WE1 target the same address, only WDATA1 SHALL be stored.
REQ-010 With ZERO_R0=1, writes to address 0 SHALL be discarded, reads of address 0 SHALL return 0 (including through the bypass), and PEND[0] SHALL stay 0.
REQ-011 The FSM SHALL have two states, CLEAR and IDLE:
- CLEAR: writes zero to the address held in a counter, then increments the counter, one address per cycle, over addresses 0..DEPTH-1.
- Transition to IDLE: after address DEPTH-1 is written.
REQ-012 READY SHALL be 1 only in IDLE.
REQ-013 In CLEAR, user writes and SB_SET SHALL be ignored, and every RDATA port SHALL read 0.
REQ-014 CLR_REQ asserted in IDLE SHALL move the FSM to CLEAR, reset the counter to 0 and zero PEND on the next edge; CLR_REQ in CLEAR SHALL restart the counter at 0.
REQ-015 A complete clear SHALL take exactly DEPTH cycles; READY SHALL rise on the edge that follows the write of address DEPTH-1.
REQ-016 Scoreboard update rules:
- SB_SET SHALL set PEND[SB_ADDR].
- A committed write from either port SHALL clear PEND[addr].
- If SB_SET and a committed write target the same address in the same cycle, the set SHALL win.
REQ-017 The address counter SHALL be ADDR_W+1 bits wide, so that reaching DEPTH is detected without wrap-around.

Reset
REQ-018 Asserting RST_N=0 SHALL, asynchronously, put the FSM in CLEAR, set the counter to 0, drive READY=0 and PEND=0.
REQ-019 After RST_N deasserts, the clear sequence SHALL run and READY SHALL rise after DEPTH cycles.
REQ-020 Array contents SHALL NOT be reset asynchronously; they are cleared only by the clear sequence.
REQ-021 Reset asserted mid-clear or mid-operation SHALL restart the clear from address 0.

Structure
REQ-022 A shared package SHALL hold the FSM state enumeration (CLEAR, IDLE) and the default DATA_W and ADDR_W constants.
REQ-023 The scoreboard SHALL be a sub-module, gpr_scoreboard, with inputs set, clear0, clear1, flush and output PEND.

Verification
REQ-024 Reset and clear: release RST_N with DEPTH=32 -> READY=0 for exactly 32 cycles, then READY=1; all 32 reads return 0.
REQ-025 Bypass: in IDLE, WE0=1, WADDR0=5, WDATA0=0xDEADBEEF, RADDR port0=5 in the same cycle -> RDATA0=0xDEADBEEF in that cycle and on following cycles.
REQ-026 Write collision: WE0 and WE1 both to address 7 with 0x11 and 0x22 -> register 7 reads 0x22; a same-cycle read also shows 0x22.
REQ-027 Register zero: write 0xFFFFFFFF to address 0 with SB_SET on address 0 -> reads 0, PEND[0]=0.
REQ-028 Scoreboard: SB_SET address 3 -> PEND[3]=1; next cycle WE1 to address 3 -> PEND[3]=0; SB_SET and WE0 to address 4 in the same cycle -> PEND[4]=1.
REQ-029 CLR_REQ mid-run: at cycle 10 of a clear pulse CLR_REQ, then in IDLE write address 9 and pulse CLR_REQ -> READY stays low 32 cycles from the last pulse; address 9 reads 0; a write issued during CLEAR is lost.
